// File: rtl/turf_bus_arbiter_pkg.sv
// Shared types and constants for the TURF register-port arbiter.
package turf_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StGap   = 2'd2,
    StFlush = 2'd3
  } arb_state_e;

  localparam int unsigned AddrW = 6;
  localparam int unsigned BankW = 2;
  localparam int unsigned DataW = 32;

  localparam logic [DataW-1:0] ErrData = 32'hDEADBEEF;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/turf_rr_grant.sv
// Combinational round-robin picker: first pending requester strictly after the pointer, wrapping.
module turf_rr_grant #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PtrW  = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PtrW-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PtrW-1:0]  idx_o,
  output logic             valid_o
);

  int unsigned     w_j;
  logic [PtrW-1:0] w_jt;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    w_j     = 0;
    w_jt    = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      w_j = 32'(ptr_i) + i;
      if (w_j >= N_REQ) w_j -= N_REQ;
      w_jt = w_j[PtrW-1:0];
      if (!valid_o && req_i[w_jt]) begin
        valid_o     = 1'b1;
        gnt_o[w_jt] = 1'b1;
        idx_o       = w_jt;
      end
    end
  end

endmodule

// File: rtl/turf_bus_arbiter.sv
// Shares the TURF parallel register port between N_REQ requesters: round-robin grant,
// one access in flight, post-ack idle gap and timeout/flush recovery.
module turf_bus_arbiter
  import turf_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned GAP_CYCLES     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned FLUSH_CYCLES   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [N_REQ-1:0]       req_rd_i,
  input  logic [N_REQ-1:0]       req_wr_i,
  input  logic [AddrW*N_REQ-1:0] req_addr_i,
  input  logic [BankW*N_REQ-1:0] req_bank_i,
  input  logic [DataW*N_REQ-1:0] req_dat_i,
  output logic [DataW-1:0]       req_dat_o,
  output logic [N_REQ-1:0]       req_ack_o,
  output logic [N_REQ-1:0]       req_err_o,
  output logic                   turf_rd_o,
  output logic                   turf_wr_o,
  output logic [AddrW-1:0]       turf_addr_o,
  output logic [BankW-1:0]       turf_bank_o,
  output logic [DataW-1:0]       turf_dat_o,
  input  logic [DataW-1:0]       turf_dat_i,
  input  logic                   turf_ack_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic                   busy_o
);

  localparam int unsigned CntW = $clog2(max_u(TIMEOUT_CYCLES, FLUSH_CYCLES) + 1);
  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] FlushLast   = CntW'(FLUSH_CYCLES - 1);

  arb_state_e       r_state;
  logic [CntW-1:0]  r_cnt;
  logic [PtrW-1:0]  r_ptr;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_ack;
  logic [N_REQ-1:0] r_err;
  logic [DataW-1:0] r_dat;
  logic             r_rd;
  logic             r_wr;
  logic [AddrW-1:0] r_addr;
  logic [BankW-1:0] r_bank;
  logic [DataW-1:0] r_wdat;

  logic [N_REQ-1:0] w_req;
  logic [N_REQ-1:0] w_gnt;
  logic [PtrW-1:0]  w_idx;
  logic             w_valid;
  logic             w_both;

  assign w_req  = req_rd_i | req_wr_i;
  assign w_both = req_rd_i[w_idx] & req_wr_i[w_idx];

  turf_rr_grant #(
    .N_REQ (N_REQ),
    .PtrW  (PtrW)
  ) u_rr_grant (
    .req_i   (w_req),
    .ptr_i   (r_ptr),
    .gnt_o   (w_gnt),
    .idx_o   (w_idx),
    .valid_o (w_valid)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_ptr   <= PtrW'(N_REQ - 1);
      r_grant <= '0;
      r_ack   <= '0;
      r_err   <= '0;
      r_dat   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_bank  <= '0;
      r_wdat  <= '0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (w_valid) begin
            r_ptr <= w_idx;
            if (w_both) begin
              // Conflicting direction: refuse without touching the port.
              r_err   <= w_gnt;
              r_dat   <= ErrData;
              r_state <= StGap;
            end else begin
              r_grant <= w_gnt;
              r_rd    <= req_rd_i[w_idx];
              r_wr    <= req_wr_i[w_idx];
              r_addr  <= req_addr_i[32'(w_idx)*AddrW +: AddrW];
              r_bank  <= req_bank_i[32'(w_idx)*BankW +: BankW];
              r_wdat  <= req_dat_i[32'(w_idx)*DataW +: DataW];
              r_state <= StIssue;
            end
          end
        end
        StIssue: begin
          if (turf_ack_i) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            if (r_rd) r_dat <= turf_dat_i;
            r_ack   <= r_grant;
            r_grant <= '0;
            r_cnt   <= '0;
            r_state <= StGap;
          end else if (r_cnt == TimeoutLast) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_dat   <= ErrData;
            r_err   <= r_grant;
            r_grant <= '0;
            r_cnt   <= '0;
            r_state <= StFlush;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StGap: begin
          if (r_cnt >= GapLast) begin
            r_cnt   <= '0;
            r_state <= StIdle;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StFlush: begin
          if (r_cnt >= FlushLast) begin
            r_cnt   <= '0;
            r_state <= StIdle;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_dat_o   = r_dat;
  assign req_ack_o   = r_ack;
  assign req_err_o   = r_err;
  assign turf_rd_o   = r_rd;
  assign turf_wr_o   = r_wr;
  assign turf_addr_o = r_addr;
  assign turf_bank_o = r_bank;
  assign turf_dat_o  = r_wdat;
  assign grant_o     = r_grant;
  assign busy_o      = (r_state != StIdle);

endmodule

// File: tb/tb_turf_bus_arbiter.sv
// Self-checking bench for turf_bus_arbiter: directed scenarios plus a randomized run against
// a transaction-level reference model with a simple port responder.
module tb_turf_bus_arbiter;

  localparam int unsigned N   = 2;
  localparam int unsigned GAP = 1;
  localparam int unsigned TO  = 255;
  localparam int unsigned FL  = 8;

  logic           clk_i = 1'b0;
  logic           rst_n_i = 1'b0;
  logic [N-1:0]   req_rd_i = '0;
  logic [N-1:0]   req_wr_i = '0;
  logic [6*N-1:0] req_addr_i = '0;
  logic [2*N-1:0] req_bank_i = '0;
  logic [32*N-1:0] req_dat_i = '0;
  logic [31:0]    req_dat_o;
  logic [N-1:0]   req_ack_o;
  logic [N-1:0]   req_err_o;
  logic           turf_rd_o;
  logic           turf_wr_o;
  logic [5:0]     turf_addr_o;
  logic [1:0]     turf_bank_o;
  logic [31:0]    turf_dat_o;
  logic [31:0]    turf_dat_i = '0;
  logic           turf_ack_i = 1'b0;
  logic [N-1:0]   grant_o;
  logic           busy_o;

  int checks = 0;
  int failures = 0;

  // Port responder state
  logic [31:0] port_mem [256];
  logic [31:0] ref_mem  [256];
  logic [39:0] port_wlog[$];
  int          port_cnt = 0;
  int          port_delay = 0;
  bit          port_never = 1'b0;
  bit          port_rand = 1'b0;

  turf_bus_arbiter #(
    .N_REQ          (N),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO),
    .FLUSH_CYCLES   (FL)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_rd_i    (req_rd_i),
    .req_wr_i    (req_wr_i),
    .req_addr_i  (req_addr_i),
    .req_bank_i  (req_bank_i),
    .req_dat_i   (req_dat_i),
    .req_dat_o   (req_dat_o),
    .req_ack_o   (req_ack_o),
    .req_err_o   (req_err_o),
    .turf_rd_o   (turf_rd_o),
    .turf_wr_o   (turf_wr_o),
    .turf_addr_o (turf_addr_o),
    .turf_bank_o (turf_bank_o),
    .turf_dat_o  (turf_dat_o),
    .turf_dat_i  (turf_dat_i),
    .turf_ack_i  (turf_ack_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Port responder: acks a strobe after port_delay cycles with a one-cycle pulse.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_n_i || turf_ack_i) begin
        turf_ack_i = 1'b0;
        port_cnt   = 0;
      end else if ((turf_rd_o || turf_wr_o) && !port_never) begin
        if (port_cnt >= port_delay) begin
          turf_ack_i = 1'b1;
          if (turf_rd_o) begin
            turf_dat_i = port_mem[{turf_bank_o, turf_addr_o}];
          end else begin
            turf_dat_i = $urandom;
            port_mem[{turf_bank_o, turf_addr_o}] = turf_dat_o;
            port_wlog.push_back({turf_bank_o, turf_addr_o, turf_dat_o});
          end
          port_cnt = 0;
          if (port_rand) port_delay = $urandom_range(0, 3);
        end else begin
          port_cnt++;
        end
      end else begin
        port_cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_req(input int k, input bit rd, input bit wr, input logic [5:0] a,
                         input logic [1:0] b, input logic [31:0] d);
    req_rd_i[k] = rd;
    req_wr_i[k] = wr;
    req_addr_i[6*k +: 6] = a;
    req_bank_i[2*k +: 2] = b;
    req_dat_i[32*k +: 32] = d;
  endtask

  task automatic reset_dut();
    rst_n_i    = 1'b0;
    req_rd_i   = '0;
    req_wr_i   = '0;
    req_addr_i = '0;
    req_bank_i = '0;
    req_dat_i  = '0;
    port_never = 1'b0;
    port_rand  = 1'b0;
    port_delay = 0;
    port_wlog.delete();
    repeat (2) @(posedge clk_i);
    #2;
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    #3;
    checks++;
    if ({grant_o, req_ack_o, req_err_o, turf_rd_o, turf_wr_o, busy_o} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: grant=%b ack=%b err=%b rd=%b wr=%b busy=%b, want all 0",
               grant_o, req_ack_o, req_err_o, turf_rd_o, turf_wr_o, busy_o);
    end
    checks++;
    if ({req_dat_o, turf_addr_o, turf_bank_o, turf_dat_o} !== '0) begin
      failures++;
      $display("FAIL reset_data: dat_o=%h addr=%h bank=%h tdat=%h, want 0",
               req_dat_o, turf_addr_o, turf_bank_o, turf_dat_o);
    end
    reset_dut();
    step();
    checks++;
    if ({grant_o, turf_rd_o, turf_wr_o, busy_o} !== '0) begin
      failures++;
      $display("FAIL reset_idle: grant=%b rd=%b wr=%b busy=%b, want 0",
               grant_o, turf_rd_o, turf_wr_o, busy_o);
    end
  endtask

  task automatic test_single_write();
    bit seen;
    reset_dut();
    port_delay = 2;
    set_req(0, 1'b0, 1'b1, 6'h05, 2'd1, 32'h11223344);
    step();
    checks++;
    if (turf_wr_o !== 1'b1 || turf_rd_o !== 1'b0 || grant_o !== 2'b01 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL wr_latency: wr=%b rd=%b grant=%b busy=%b, want 1 0 01 1",
               turf_wr_o, turf_rd_o, grant_o, busy_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (req_ack_o !== '0) begin
        seen = 1'b1;
      end else begin
        checks++;
        if ({turf_wr_o, turf_rd_o, turf_addr_o, turf_bank_o, turf_dat_o} !==
            {1'b1, 1'b0, 6'h05, 2'd1, 32'h11223344}) begin
          failures++;
          $display("FAIL wr_stable: wr=%b rd=%b addr=%h bank=%h dat=%h, want 1 0 05 1 11223344",
                   turf_wr_o, turf_rd_o, turf_addr_o, turf_bank_o, turf_dat_o);
        end
      end
    end
    checks++;
    if (!seen || req_ack_o !== 2'b01 || turf_wr_o !== 1'b0 || grant_o !== 2'b00) begin
      failures++;
      $display("FAIL wr_ack: seen=%b ack=%b wr=%b grant=%b, want 1 01 0 00",
               seen, req_ack_o, turf_wr_o, grant_o);
    end
    checks++;
    if (port_wlog.size() != 1 || port_wlog[0] !== {2'd1, 6'h05, 32'h11223344}) begin
      failures++;
      $display("FAIL wr_port_data: entries=%0d, want one write of 1/05/11223344",
               port_wlog.size());
    end
    set_req(0, 1'b0, 1'b0, 6'h0, 2'd0, 32'h0);
    step();
    checks++;
    if (req_ack_o !== 2'b00 || busy_o !== 1'b0 || grant_o !== 2'b00) begin
      failures++;
      $display("FAIL wr_after_gap: ack=%b busy=%b grant=%b, want 00 0 00",
               req_ack_o, busy_o, grant_o);
    end
  endtask

  task automatic test_single_read();
    bit seen;
    reset_dut();
    port_mem[{2'd2, 6'h0A}] = 32'hCAFEF00D;
    set_req(1, 1'b1, 1'b0, 6'h0A, 2'd2, 32'h0);
    step();
    checks++;
    if (turf_rd_o !== 1'b1 || turf_wr_o !== 1'b0 || grant_o !== 2'b10 ||
        turf_addr_o !== 6'h0A || turf_bank_o !== 2'd2) begin
      failures++;
      $display("FAIL rd_issue: rd=%b wr=%b grant=%b addr=%h bank=%h, want 1 0 10 0a 2",
               turf_rd_o, turf_wr_o, grant_o, turf_addr_o, turf_bank_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (req_ack_o !== '0) seen = 1'b1;
    end
    checks++;
    if (!seen || req_ack_o !== 2'b10 || req_dat_o !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL rd_data: seen=%b ack=%b dat=%h, want 1 10 cafef00d",
               seen, req_ack_o, req_dat_o);
    end
    set_req(1, 1'b0, 1'b0, 6'h0, 2'd0, 32'h0);
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq[$];
    logic [N-1:0] prev_g;
    reset_dut();
    set_req(0, 1'b0, 1'b1, 6'h01, 2'd0, 32'hA0A0A0A0);
    set_req(1, 1'b0, 1'b1, 6'h02, 2'd3, 32'hB1B1B1B1);
    prev_g = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (grant_o !== '0 && prev_g === '0) seq.push_back(grant_o);
      prev_g = grant_o;
      if (req_ack_o !== '0) begin
        checks++;
        if (turf_rd_o !== 1'b0 || turf_wr_o !== 1'b0) begin
          failures++;
          $display("FAIL rr_no_strobe_after_ack: rd=%b wr=%b, want 0 0", turf_rd_o, turf_wr_o);
        end
      end
    end
    checks++;
    if (seq.size() < 4 || seq[0] !== 2'b01 || seq[1] !== 2'b10 ||
        seq[2] !== 2'b01 || seq[3] !== 2'b10) begin
      failures++;
      $display("FAIL rr_order: got %0d grants first=%b,%b,%b,%b, want 01,10,01,10",
               seq.size(), (seq.size() > 0) ? seq[0] : 2'bxx, (seq.size() > 1) ? seq[1] : 2'bxx,
               (seq.size() > 2) ? seq[2] : 2'bxx, (seq.size() > 3) ? seq[3] : 2'bxx);
    end
    req_rd_i = '0;
    req_wr_i = '0;
  endtask

  task automatic test_timeout();
    int errat;
    int n;
    bit seen;
    reset_dut();
    port_never = 1'b1;
    set_req(0, 1'b0, 1'b1, 6'h11, 2'd0, 32'h55AA55AA);
    step();
    errat = -1;
    for (int i = 1; i <= int'(TO) + 5 && errat < 0; i++) begin
      step();
      if (req_err_o !== '0) begin
        errat = i;
      end else if (turf_wr_o !== 1'b1) begin
        checks++;
        failures++;
        $display("FAIL to_strobe_held: wr=%b at cycle %0d, want 1", turf_wr_o, i);
      end
    end
    checks++;
    if (errat != int'(TO)) begin
      failures++;
      $display("FAIL to_latency: err after %0d cycles, want %0d", errat, TO);
    end
    checks++;
    if (req_err_o !== 2'b01 || req_dat_o !== 32'hDEADBEEF || turf_wr_o !== 1'b0 ||
        grant_o !== 2'b00 || req_ack_o !== 2'b00) begin
      failures++;
      $display("FAIL to_err: err=%b dat=%h wr=%b grant=%b ack=%b, want 01 deadbeef 0 00 00",
               req_err_o, req_dat_o, turf_wr_o, grant_o, req_ack_o);
    end
    set_req(0, 1'b0, 1'b0, 6'h0, 2'd0, 32'h0);
    port_never = 1'b0;
    set_req(1, 1'b1, 1'b0, 6'h12, 2'd1, 32'h0);
    n = 0;
    while (grant_o === '0 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n != int'(FL) + 1 || grant_o !== 2'b10) begin
      failures++;
      $display("FAIL to_flush: grant %b after %0d cycles, want 10 after %0d", grant_o, n, FL + 1);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (req_ack_o !== '0) seen = 1'b1;
    end
    checks++;
    if (!seen || req_ack_o !== 2'b10) begin
      failures++;
      $display("FAIL to_recover: seen=%b ack=%b, want 1 10", seen, req_ack_o);
    end
    set_req(1, 1'b0, 1'b0, 6'h0, 2'd0, 32'h0);
  endtask

  task automatic test_rd_wr_both();
    int strobes;
    int errs;
    reset_dut();
    set_req(0, 1'b1, 1'b1, 6'h07, 2'd2, 32'h12345678);
    step();
    checks++;
    if (req_err_o !== 2'b01 || req_dat_o !== 32'hDEADBEEF || grant_o !== 2'b00 ||
        turf_rd_o !== 1'b0 || turf_wr_o !== 1'b0) begin
      failures++;
      $display("FAIL both_err: err=%b dat=%h grant=%b rd=%b wr=%b, want 01 deadbeef 00 0 0",
               req_err_o, req_dat_o, grant_o, turf_rd_o, turf_wr_o);
    end
    set_req(0, 1'b0, 1'b0, 6'h0, 2'd0, 32'h0);
    strobes = 0;
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (turf_rd_o || turf_wr_o) strobes++;
      if (req_err_o !== '0) errs++;
    end
    checks++;
    if (strobes != 0 || errs != 0) begin
      failures++;
      $display("FAIL both_quiet: strobe cycles=%0d extra err pulses=%0d, want 0 0", strobes, errs);
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    port_never = 1'b1;
    set_req(0, 1'b1, 1'b0, 6'h03, 2'd1, 32'h0);
    step();
    checks++;
    if (turf_rd_o !== 1'b1 || grant_o !== 2'b01) begin
      failures++;
      $display("FAIL ar_issue: rd=%b grant=%b, want 1 01", turf_rd_o, grant_o);
    end
    set_req(1, 1'b0, 1'b1, 6'h04, 2'd0, 32'h0BADF00D);
    repeat (3) step();
    #1;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({grant_o, req_ack_o, req_err_o, turf_rd_o, turf_wr_o, busy_o, req_dat_o,
         turf_addr_o, turf_bank_o, turf_dat_o} !== '0) begin
      failures++;
      $display("FAIL ar_async: grant=%b rd=%b wr=%b busy=%b addr=%h, want all 0",
               grant_o, turf_rd_o, turf_wr_o, busy_o, turf_addr_o);
    end
    port_never = 1'b0;
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b1;
    step();
    checks++;
    if (grant_o !== 2'b01 || turf_rd_o !== 1'b1) begin
      failures++;
      $display("FAIL ar_first_grant: grant=%b rd=%b, want 01 1", grant_o, turf_rd_o);
    end
    req_rd_i = '0;
    req_wr_i = '0;
  endtask

  task automatic test_random();
    bit          act[N];
    bit          prev_act[N];
    bit          done_now[N];
    bit          t_rd[N];
    logic [5:0]  t_addr[N];
    logic [1:0]  t_bank[N];
    logic [31:0] t_dat[N];
    int          owner;
    int          left;
    int          ptr;
    int          w;
    int          ncompl;
    bit          was_idle;
    bit          exp_busy;
    logic [31:0] mdat;
    logic [N-1:0] eg;
    logic [39:0] wl;

    reset_dut();
    port_rand  = 1'b1;
    port_delay = 1;
    for (int i = 0; i < 256; i++) begin
      port_mem[i] = $urandom;
      ref_mem[i]  = port_mem[i];
    end
    for (int k = 0; k < int'(N); k++) begin
      act[k] = 1'b0;
      prev_act[k] = 1'b0;
      done_now[k] = 1'b0;
    end
    owner  = -1;
    left   = 0;
    ptr    = N - 1;
    mdat   = '0;
    ncompl = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      was_idle = (owner < 0 && left == 0);
      if (left > 0) left--;
      w = -1;
      if (was_idle) begin
        for (int i = 1; i <= int'(N); i++) begin
          int j;
          j = (ptr + i) % N;
          if (w < 0 && prev_act[j]) w = j;
        end
      end
      if (w >= 0) begin
        eg = '0;
        eg[w] = 1'b1;
        checks++;
        if (grant_o !== eg || turf_rd_o !== t_rd[w] || turf_wr_o !== !t_rd[w] ||
            turf_addr_o !== t_addr[w] || turf_bank_o !== t_bank[w] || turf_dat_o !== t_dat[w]) begin
          failures++;
          $display("FAIL rnd_grant: cyc %0d grant=%b rd=%b wr=%b addr=%h, want grant=%b rd=%b addr=%h",
                   cyc, grant_o, turf_rd_o, turf_wr_o, turf_addr_o, eg, t_rd[w], t_addr[w]);
        end
        owner = w;
        ptr   = w;
      end else if (owner >= 0) begin
        eg = '0;
        eg[owner] = 1'b1;
        if (req_ack_o !== '0) begin
          checks++;
          if (req_ack_o !== eg || grant_o !== '0 || turf_rd_o || turf_wr_o) begin
            failures++;
            $display("FAIL rnd_ack: cyc %0d ack=%b grant=%b rd=%b wr=%b, want ack=%b idle port",
                     cyc, req_ack_o, grant_o, turf_rd_o, turf_wr_o, eg);
          end
          if (t_rd[owner]) begin
            mdat = ref_mem[{t_bank[owner], t_addr[owner]}];
          end else begin
            wl = (port_wlog.size() > 0) ? port_wlog.pop_front() : 40'h0;
            checks++;
            if (wl !== {t_bank[owner], t_addr[owner], t_dat[owner]}) begin
              failures++;
              $display("FAIL rnd_wdata: cyc %0d port saw %h, want %h", cyc, wl,
                       {t_bank[owner], t_addr[owner], t_dat[owner]});
            end
            ref_mem[{t_bank[owner], t_addr[owner]}] = t_dat[owner];
          end
          checks++;
          if (req_dat_o !== mdat) begin
            failures++;
            $display("FAIL rnd_rdata: cyc %0d dat=%h, want %h", cyc, req_dat_o, mdat);
          end
          req_rd_i[owner] = 1'b0;
          req_wr_i[owner] = 1'b0;
          act[owner]      = 1'b0;
          done_now[owner] = 1'b1;
          ncompl++;
          owner = -1;
          left  = GAP;
        end else begin
          checks++;
          if (grant_o !== eg || turf_rd_o !== t_rd[owner] || turf_wr_o !== !t_rd[owner] ||
              turf_addr_o !== t_addr[owner] || turf_dat_o !== t_dat[owner]) begin
            failures++;
            $display("FAIL rnd_hold: cyc %0d grant=%b rd=%b wr=%b addr=%h, want %b %b addr=%h",
                     cyc, grant_o, turf_rd_o, turf_wr_o, turf_addr_o, eg, t_rd[owner],
                     t_addr[owner]);
          end
        end
      end else begin
        checks++;
        if (grant_o !== '0 || req_ack_o !== '0 || turf_rd_o || turf_wr_o) begin
          failures++;
          $display("FAIL rnd_quiet: cyc %0d grant=%b ack=%b rd=%b wr=%b, want all 0",
                   cyc, grant_o, req_ack_o, turf_rd_o, turf_wr_o);
        end
      end
      exp_busy = (owner >= 0) || (left > 0);
      checks++;
      if (busy_o !== exp_busy || req_err_o !== '0) begin
        failures++;
        $display("FAIL rnd_busy: cyc %0d busy=%b err=%b, want busy=%b err=0",
                 cyc, busy_o, req_err_o, exp_busy);
      end
      for (int k = 0; k < int'(N); k++) begin
        if (!act[k] && !done_now[k] && cyc < 500 && $urandom_range(0, 2) == 0) begin
          t_rd[k]   = $urandom_range(0, 1);
          t_addr[k] = 6'($urandom);
          t_bank[k] = 2'($urandom);
          t_dat[k]  = $urandom;
          set_req(k, t_rd[k], !t_rd[k], t_addr[k], t_bank[k], t_dat[k]);
          act[k] = 1'b1;
        end
        done_now[k] = 1'b0;
        prev_act[k] = act[k];
      end
    end
    checks++;
    if (act[0] || act[1] || ncompl < 20) begin
      failures++;
      $display("FAIL rnd_drain: pending=%b%b completions=%0d, want none pending and >=20",
               act[1], act[0], ncompl);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_rd_wr_both();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
